trainerror_responder: RTL

Sideband responder for the TRAINERROR entry handshake, the partner-side counterpart of the LTSM's TRAINERROR initiator. It watches the sideband RX path for a TRAINERROR_Entry_req from the remote die and tells the LTSM to force a transition. Once the LTSM reports it is in TRAINERROR, it returns TRAINERROR_Entry_resp on the sideband TX path. It sits between the LTSM top and the SB message mux, in the 100 MHz sideband domain.

---
 rtl/trainerror_responder.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/trainerror_responder.sv
// trainerror_responder: partner-side TRAINERROR entry handshake.
// Watches the sideband RX path for TRAINERROR_Entry_req and asks the LTSM
// to enter TRAINERROR. Once the LTSM reports it is there, the block returns
// TRAINERROR_Entry_resp on the sideband TX path. All outputs are registered.
// Lives in the 100 MHz sideband clock domain.

package trainerror_responder_pkg;

  // Sideband message encodings seen by this block. The all-zero code means
  // "no message" and is what the TX message port shows while idle.
  typedef enum logic [4:0] {
    SB_NONE                  = 5'd0,
    SB_SBINIT_DONE_REQ       = 5'd1,
    SB_SBINIT_DONE_RESP      = 5'd2,
    SB_LINKINIT_REQ          = 5'd3,
    SB_TRAINERROR_ENTRY_REQ  = 5'd4,
    SB_TRAINERROR_ENTRY_RESP = 5'd5
  } SB_msg_t;

endpackage : trainerror_responder_pkg

module trainerror_responder
  import trainerror_responder_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 800000
) (
  input  logic        clk_100MHz,
  input  logic        reset,
  input  logic        enable_i,
  input  logic        ltsm_in_trainerror_i,
  output logic        partner_trainerror_req_o,
  output logic        resp_sent_o,
  output logic        timeout_o,
  output SB_msg_t     SB_TX_msg_o,
  output logic [63:0] SB_TX_dataBus_o,
  output logic        SB_TX_msg_valid_o,
  input  logic        SB_TX_msg_sendNextFlag_i,
  input  SB_msg_t     SB_RX_msg_i,
  input  logic [63:0] SB_RX_dataBus_i,
  output logic        SB_RX_msg_req_o,
  input  logic        SB_RX_msg_valid_i
);

  // Guard keeps the counter at least one bit wide for tiny timeouts.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_LTSM,
    SEND_RESP,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic    rx_beat;
  logic    rx_entry_req;
  logic    timeout_d;
  logic    partner_req_d;
  logic    resp_sent_d;
  logic    tx_valid_d;
  SB_msg_t tx_msg_d;
  logic    rx_req_d;

  // RX payload carries nothing this block needs.
  logic unused_rx_data;
  assign unused_rx_data = ^SB_RX_dataBus_i;

  // The response carries no payload.
  assign SB_TX_dataBus_o = '0;

  // An RX beat needs both valid and our own registered ready; valid alone
  // while ready is low is not a transfer.
  assign rx_beat      = SB_RX_msg_valid_i && SB_RX_msg_req_o;
  assign rx_entry_req = rx_beat && (SB_RX_msg_i == SB_TRAINERROR_ENTRY_REQ);

  // Next-state, counter and next-output decode.
  always_comb begin
    // NOTE: every signal written here gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;

    if (!enable_i) begin
      // Disarming wins over every other event and aborts any pending TX.
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // Non-request messages are consumed and dropped.
          if (rx_entry_req) begin
            state_d = WAIT_LTSM;
            cnt_d   = '0;
          end
        end

        WAIT_LTSM: begin
          // LTSM arrival beats the terminal count on the same edge.
          if (ltsm_in_trainerror_i) begin
            state_d = SEND_RESP;
          end else if (cnt_q == CNT_TERM) begin
            state_d   = IDLE;
            timeout_d = 1'b1;
          end else begin
            // Only reached below the terminal count, so it saturates there.
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        SEND_RESP: begin
          // Valid is always high in this state, so accept alone is the transfer.
          if (SB_TX_msg_sendNextFlag_i) begin
            state_d = DONE;
          end
        end

        DONE: begin
          // A partner retry earns a fresh response.
          if (rx_entry_req) begin
            state_d = SEND_RESP;
          end
        end

        default: state_d = IDLE;
      endcase
    end

    // Outputs are a function of where we land, then registered.
    partner_req_d = (state_d != IDLE);
    resp_sent_d   = (state_d == DONE);
    tx_valid_d    = (state_d == SEND_RESP);
    tx_msg_d      = (state_d == SEND_RESP) ? SB_TRAINERROR_ENTRY_RESP : SB_NONE;
    rx_req_d      = enable_i && (state_d != SEND_RESP);
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state_q                  <= IDLE;
      cnt_q                    <= '0;
      partner_trainerror_req_o <= 1'b0;
      resp_sent_o              <= 1'b0;
      timeout_o                <= 1'b0;
      SB_TX_msg_o              <= SB_NONE;
      SB_TX_msg_valid_o        <= 1'b0;
      SB_RX_msg_req_o          <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values,
      // independent of statement order.
      state_q                  <= state_d;
      cnt_q                    <= cnt_d;
      partner_trainerror_req_o <= partner_req_d;
      resp_sent_o              <= resp_sent_d;
      timeout_o                <= timeout_d;
      SB_TX_msg_o              <= tx_msg_d;
      SB_TX_msg_valid_o        <= tx_valid_d;
      SB_RX_msg_req_o          <= rx_req_d;
    end
  end

  // Handshake invariants.

  // Message and valid stay put while the TX path holds off.
  a_tx_stable : assert property (
    @(posedge clk_100MHz) disable iff (reset)
    (SB_TX_msg_valid_o && !SB_TX_msg_sendNextFlag_i && enable_i)
      |=> (SB_TX_msg_valid_o && $stable(SB_TX_msg_o))
  );

  // Timeout is a single-cycle pulse and leaves the LTSM request dropped.
  a_timeout_pulse : assert property (
    @(posedge clk_100MHz) disable iff (reset)
    timeout_o |-> (!partner_trainerror_req_o ##1 !timeout_o)
  );

  // RX is never offered while a response is in flight.
  a_rx_quiet_in_tx : assert property (
    @(posedge clk_100MHz) disable iff (reset)
    SB_TX_msg_valid_o |-> !SB_RX_msg_req_o
  );

  // A delivered response implies the LTSM request is still held.
  a_done_holds_req : assert property (
    @(posedge clk_100MHz) disable iff (reset)
    resp_sent_o |-> partner_trainerror_req_o
  );

endmodule : trainerror_responder
